// File: rtl/mips_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: control_type codes,
// fetch FSM state codes, the default reset PC and the branch offset helper.
package mips_fetch_pkg;

    typedef logic [1:0] ctrl_type_t;

    localparam logic [31:0] RESET_PC_DEF = 32'h0040_0000;

    localparam ctrl_type_t CT_NEXT   = 2'd0;
    localparam ctrl_type_t CT_BRANCH = 2'd1;
    localparam ctrl_type_t CT_JUMP   = 2'd2;
    localparam ctrl_type_t CT_JR     = 2'd3;

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_HOLD  = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    // Sign-extended word offset of a conditional branch, in bytes.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/mips_fetch_if.sv
// Fetch unit bus: instruction memory handshake plus the decoder-facing
// instruction/PC signals. master = fetch unit, slave = memory/decoder side.
interface mips_fetch_if;
    import mips_fetch_pkg::*;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        inst_valid;
    logic        inst_ack;
    ctrl_type_t  control_type;
    logic        except;
    logic [31:0] jr_target;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        halted;
    logic        misaligned;

    modport master (
        output imem_req, imem_addr, inst, opcode, funct, inst_valid,
               pc, pc_plus4, halted, misaligned,
        input  imem_ready, imem_rdata, inst_ack, control_type, except, jr_target
    );

    modport slave (
        input  imem_req, imem_addr, inst, opcode, funct, inst_valid,
               pc, pc_plus4, halted, misaligned,
        output imem_ready, imem_rdata, inst_ack, control_type, except, jr_target
    );

endinterface

// File: rtl/mips_fetch_next_pc.sv
// Combinational next-PC selection from the decoder's control_type, plus
// detection of a jr target that is not word aligned.
module mips_fetch_next_pc
    import mips_fetch_pkg::*;
(
    input  logic [31:0] i_pc,
    input  logic [25:0] i_inst_lo,
    input  ctrl_type_t  i_control_type,
    input  logic [31:0] i_jr_target,
    output logic [31:0] o_pc_plus4,
    output logic [31:0] o_next_pc,
    output logic        o_misaligned
);

    logic [31:0] w_pc_plus4;

    assign w_pc_plus4 = i_pc + 32'd4;
    assign o_pc_plus4 = w_pc_plus4;

    // All arithmetic is modulo 2^32; wrap past the top of memory is silent.
    always_comb begin
        o_next_pc = w_pc_plus4;
        case (i_control_type)
            CT_BRANCH: o_next_pc = w_pc_plus4 + branch_offset(i_inst_lo[15:0]);
            CT_JUMP:   o_next_pc = {w_pc_plus4[31:28], i_inst_lo, 2'b00};
            CT_JR:     o_next_pc = i_jr_target;
            default:   o_next_pc = w_pc_plus4;
        endcase
    end

    assign o_misaligned = (i_control_type == CT_JR) && (i_jr_target[1:0] != 2'b00);

endmodule

// File: rtl/mips_fetch.sv
// Instruction fetch unit: owns the PC, fetches over a req/ready handshake,
// holds the instruction until execute acks, then applies the next PC or halts.
module mips_fetch
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic          i_clock,
    input  logic          i_reset,
    mips_fetch_if.master  bus
);

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic        r_inst_valid;
    logic        r_halted;
    logic        r_misaligned;

    logic [31:0] w_next_pc;
    logic [31:0] w_pc_plus4;
    logic        w_jr_misaligned;

    mips_fetch_next_pc u_next_pc (
        .i_pc           (r_pc),
        .i_inst_lo      (r_inst[25:0]),
        .i_control_type (bus.control_type),
        .i_jr_target    (bus.jr_target),
        .o_pc_plus4     (w_pc_plus4),
        .o_next_pc      (w_next_pc),
        .o_misaligned   (w_jr_misaligned)
    );

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= ST_FETCH;
            r_pc         <= RESET_PC;
            r_inst       <= 32'h0;
            r_inst_valid <= 1'b0;
            r_halted     <= 1'b0;
            r_misaligned <= 1'b0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (bus.imem_ready) begin
                        r_inst       <= bus.imem_rdata;
                        r_inst_valid <= 1'b1;
                        r_state      <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // except outranks any control_type presented in the same ack.
                    if (bus.inst_ack) begin
                        r_inst_valid <= 1'b0;
                        if (bus.except) begin
                            r_halted <= 1'b1;
                            r_state  <= ST_HALT;
                        end else if (w_jr_misaligned) begin
                            r_halted     <= 1'b1;
                            r_misaligned <= 1'b1;
                            r_state      <= ST_HALT;
                        end else begin
                            r_pc    <= w_next_pc;
                            r_state <= ST_FETCH;
                        end
                    end
                end
                default: r_state <= ST_HALT;
            endcase
        end
    end

    assign bus.imem_req   = (r_state == ST_FETCH);
    assign bus.imem_addr  = r_pc;
    assign bus.inst       = r_inst;
    assign bus.opcode     = r_inst[31:26];
    assign bus.funct      = r_inst[5:0];
    assign bus.inst_valid = r_inst_valid;
    assign bus.pc         = r_pc;
    assign bus.pc_plus4   = w_pc_plus4;
    assign bus.halted     = r_halted;
    assign bus.misaligned = r_misaligned;

endmodule

// File: tb/tb_mips_fetch.sv
// Self-checking bench for mips_fetch: directed scenarios plus a randomized
// instruction stream checked against an arithmetic next-PC model.
module tb_mips_fetch;
    import mips_fetch_pkg::*;

    localparam logic [31:0] RPC = 32'h0040_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    mips_fetch_if bus();

    mips_fetch #(.RESET_PC(RPC)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got running exp finished");
        $fatal(1, "watchdog");
    end

    // Reference next-PC, straight from the instruction-set rules.
    function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] w,
                                               input int ct, input logic [31:0] jt);
        longint off;
        off = longint'($signed(w[15:0])) * 4;
        case (ct)
            0:       return pc + 32'd4;
            1:       return 32'(longint'(pc) + 4 + off);
            2:       return ((pc + 32'd4) & 32'hF000_0000) | ((w & 32'h03FF_FFFF) * 4);
            default: return jt;
        endcase
    endfunction

    task automatic drive_idle();
        bus.imem_ready   = 1'b0;
        bus.imem_rdata   = 32'h0;
        bus.inst_ack     = 1'b0;
        bus.control_type = 2'd0;
        bus.except       = 1'b0;
        bus.jr_target    = 32'h0;
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Delay cycles carry random inst_ack, which must be ignored in FETCH.
    task automatic fetch_word(input logic [31:0] w, input int dly);
        for (int i = 0; i < dly; i++) begin
            bus.inst_ack = 1'($urandom);
            @(negedge clk);
        end
        bus.imem_ready = 1'b1;
        bus.imem_rdata = w;
        @(negedge clk);
        bus.imem_ready = 1'b0;
        bus.inst_ack   = 1'b0;
        bus.imem_rdata = $urandom;
    endtask

    task automatic ack(input logic [1:0] ct, input logic ex, input logic [31:0] jt);
        bus.inst_ack     = 1'b1;
        bus.control_type = ct;
        bus.except       = ex;
        bus.jr_target    = jt;
        @(negedge clk);
        bus.inst_ack     = 1'b0;
        bus.except       = 1'b0;
        bus.control_type = 2'($urandom);
        bus.jr_target    = $urandom;
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1'b1;
        @(negedge clk);
        tests++; if (bus.pc !== RPC) begin fails++; $display("FAIL reset_pc: got %h exp %h", bus.pc, RPC); end
        tests++; if (bus.inst !== 32'h0) begin fails++; $display("FAIL reset_inst: got %h exp 0", bus.inst); end
        tests++; if (bus.inst_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b exp 0", bus.inst_valid); end
        tests++; if (bus.halted !== 1'b0 || bus.misaligned !== 1'b0) begin fails++; $display("FAIL reset_halt: got %b%b exp 00", bus.halted, bus.misaligned); end
        rst = 1'b0;
        @(negedge clk);
        tests++; if (bus.imem_req !== 1'b1) begin fails++; $display("FAIL reset_req: got %b exp 1", bus.imem_req); end
        tests++; if (bus.imem_addr !== RPC) begin fails++; $display("FAIL reset_addr: got %h exp %h", bus.imem_addr, RPC); end
    endtask

    task automatic test_first_fetch();
        fetch_word(32'h0000_0020, 0);
        tests++; if (bus.inst_valid !== 1'b1) begin fails++; $display("FAIL ff_valid: got %b exp 1", bus.inst_valid); end
        tests++; if (bus.opcode !== 6'h00) begin fails++; $display("FAIL ff_opcode: got %h exp 00", bus.opcode); end
        tests++; if (bus.funct !== 6'h20) begin fails++; $display("FAIL ff_funct: got %h exp 20", bus.funct); end
        tests++; if (bus.imem_req !== 1'b0) begin fails++; $display("FAIL ff_req_hold: got %b exp 0", bus.imem_req); end
        tests++; if (bus.pc_plus4 !== 32'h0040_0004) begin fails++; $display("FAIL ff_pc_plus4: got %h exp 00400004", bus.pc_plus4); end
    endtask

    task automatic test_ready_delay();
        ack(2'd0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tests++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0040_0004) begin fails++; $display("FAIL delay_req[%0d]: got %b/%h exp 1/00400004", i, bus.imem_req, bus.imem_addr); end
            tests++; if (bus.inst_valid !== 1'b0) begin fails++; $display("FAIL delay_valid[%0d]: got %b exp 0", i, bus.inst_valid); end
            @(negedge clk);
        end
        bus.imem_ready = 1'b1;
        bus.imem_rdata = 32'h2408_0001;
        @(negedge clk);
        bus.imem_ready = 1'b0;
        tests++; if (bus.inst_valid !== 1'b1 || bus.inst !== 32'h2408_0001) begin fails++; $display("FAIL delay_after: got %b/%h exp 1/24080001", bus.inst_valid, bus.inst); end
    endtask

    task automatic test_branch();
        repeat (2) begin
            ack(2'd0, 1'b0, 32'h0);
            fetch_word(32'h0, 0);
        end
        ack(2'd0, 1'b0, 32'h0);
        tests++; if (bus.imem_addr !== 32'h0040_0010) begin fails++; $display("FAIL br_setup: got %h exp 00400010", bus.imem_addr); end
        fetch_word(32'h1000_FFFF, 0);
        ack(2'd1, 1'b0, 32'h0);
        tests++; if (bus.imem_addr !== 32'h0040_0010) begin fails++; $display("FAIL br_back: got %h exp 00400010", bus.imem_addr); end
        fetch_word(32'h1000_0003, 0);
        ack(2'd1, 1'b0, 32'h0);
        tests++; if (bus.imem_addr !== 32'h0040_0020) begin fails++; $display("FAIL br_fwd: got %h exp 00400020", bus.imem_addr); end
    endtask

    task automatic test_jump_jr();
        fetch_word(32'h0810_0000, 0);
        ack(2'd2, 1'b0, 32'h0);
        tests++; if (bus.imem_addr !== 32'h0040_0000) begin fails++; $display("FAIL j_target: got %h exp 00400000", bus.imem_addr); end
        fetch_word(32'h03E0_0008, 0);
        ack(2'd3, 1'b0, 32'h0040_0102);
        tests++; if (bus.halted !== 1'b1 || bus.misaligned !== 1'b1) begin fails++; $display("FAIL jr_halt: got %b%b exp 11", bus.halted, bus.misaligned); end
        tests++; if (bus.inst_valid !== 1'b0) begin fails++; $display("FAIL jr_valid: got %b exp 0", bus.inst_valid); end
        for (int i = 0; i < 4; i++) begin
            bus.imem_ready = 1'b1;
            bus.inst_ack   = 1'b1;
            bus.control_type = 2'd0;
            @(negedge clk);
            tests++; if (bus.imem_req !== 1'b0 || bus.pc !== 32'h0040_0000) begin fails++; $display("FAIL halt_frozen[%0d]: got %b/%h exp 0/00400000", i, bus.imem_req, bus.pc); end
        end
        drive_idle();
    endtask

    task automatic test_except();
        do_reset();
        fetch_word(32'hFC00_0000, 1);
        ack(2'd2, 1'b1, 32'h0);
        tests++; if (bus.halted !== 1'b1 || bus.misaligned !== 1'b0) begin fails++; $display("FAIL exc_halt: got %b%b exp 10", bus.halted, bus.misaligned); end
        tests++; if (bus.pc !== RPC || bus.imem_req !== 1'b0) begin fails++; $display("FAIL exc_pc: got %h/%b exp %h/0", bus.pc, bus.imem_req, RPC); end
        #2 rst = 1'b1;
        #1;
        tests++; if (bus.halted !== 1'b0 || bus.inst_valid !== 1'b0 || bus.pc !== RPC) begin fails++; $display("FAIL rst_in_halt: got %b/%b/%h exp 0/0/%h", bus.halted, bus.inst_valid, bus.pc, RPC); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        fetch_word(32'h0810_0010, 0);
        ack(2'd2, 1'b0, 32'h0);
        tests++; if (bus.imem_addr !== 32'h0040_0040 || bus.imem_req !== 1'b1) begin fails++; $display("FAIL exc_setup: got %h/%b exp 00400040/1", bus.imem_addr, bus.imem_req); end
        #2 rst = 1'b1;
        #1;
        tests++; if (bus.pc !== RPC || bus.inst_valid !== 1'b0 || bus.halted !== 1'b0) begin fails++; $display("FAIL rst_in_fetch: got %h/%b/%b exp %h/0/0", bus.pc, bus.inst_valid, bus.halted, RPC); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_wrap();
        do_reset();
        fetch_word(32'h0, 0);
        ack(2'd3, 1'b0, 32'hFFFF_FFFC);
        tests++; if (bus.imem_addr !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_jr: got %h exp fffffffc", bus.imem_addr); end
        tests++; if (bus.pc_plus4 !== 32'h0) begin fails++; $display("FAIL wrap_plus4: got %h exp 0", bus.pc_plus4); end
        fetch_word(32'h0, 0);
        ack(2'd0, 1'b0, 32'h0);
        tests++; if (bus.imem_addr !== 32'h0) begin fails++; $display("FAIL wrap_next: got %h exp 0", bus.imem_addr); end
    endtask

    task automatic test_random();
        logic [31:0] mpc, w, jt;
        int ct, n;
        do_reset();
        mpc = RPC;
        for (int it = 0; it < 60; it++) begin
            tests++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== mpc) begin fails++; $display("FAIL rnd_addr[%0d]: got %b/%h exp 1/%h", it, bus.imem_req, bus.imem_addr, mpc); end
            w = $urandom;
            fetch_word(w, $urandom_range(0, 3));
            tests++; if (bus.inst_valid !== 1'b1 || bus.inst !== w) begin fails++; $display("FAIL rnd_inst[%0d]: got %b/%h exp 1/%h", it, bus.inst_valid, bus.inst, w); end
            tests++; if (bus.opcode !== w[31:26] || bus.funct !== w[5:0]) begin fails++; $display("FAIL rnd_fields[%0d]: got %h/%h exp %h/%h", it, bus.opcode, bus.funct, w[31:26], w[5:0]); end
            tests++; if (bus.pc !== mpc || bus.pc_plus4 !== mpc + 32'd4) begin fails++; $display("FAIL rnd_pc[%0d]: got %h/%h exp %h", it, bus.pc, bus.pc_plus4, mpc); end
            n = $urandom_range(0, 2);
            for (int k = 0; k < n; k++) begin
                bus.imem_ready = 1'b1;
                bus.imem_rdata = $urandom;
                @(negedge clk);
                tests++; if (bus.inst !== w || bus.inst_valid !== 1'b1) begin fails++; $display("FAIL rnd_hold[%0d]: got %h exp %h", it, bus.inst, w); end
            end
            bus.imem_ready = 1'b0;
            ct = $urandom_range(0, 3);
            jt = $urandom;
            jt[1:0] = 2'b00;
            ack(2'(ct), 1'b0, jt);
            mpc = model_next(mpc, w, ct, jt);
        end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_ready_delay();
        test_branch();
        test_jump_jr();
        test_except();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
